// File: rtl/mem_responder.sv
// Single-port memory responder: data RAM and external-ROM fetch behind an IDLE/WAIT/RESP handshake.
// Optional per-byte even parity on the RAM is enabled by defining MEM_RESPONDER_PARITY_EN.
module mem_responder #(
  parameter int WAIT_CYC = 0,
  parameter int RAM_AW   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ram_ena,
  input  logic       ram_read,
  input  logic       ram_write,
  input  logic       rom_ena,
  input  logic       rom_read,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_q,
  output logic [7:0] rdata,
  output logic       ready,
  output logic       busy,
  output logic       err
);

  localparam int DEPTH = 1 << RAM_AW;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {K_BAD, K_RD, K_WR, K_ROM} kind_t;

  state_t            state_q, state_d;
  kind_t             kind_q, kind_d, kind_in, kind_eff;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              req, idle, to_resp, oor, bad, we, perr, perr_raw;
  logic [7:0]        addr_eff, wdata_eff;
  logic [RAM_AW-1:0] ram_idx;
  logic [7:0]        mem [DEPTH];

  always_comb begin
    req     = ram_ena | ram_read | ram_write | rom_ena | rom_read;
    kind_in = K_BAD;
    if (ram_ena & !rom_ena & ram_read & !ram_write)      kind_in = K_RD;
    else if (ram_ena & !rom_ena & ram_write & !ram_read) kind_in = K_WR;
    else if (rom_ena & rom_read & !ram_ena)              kind_in = K_ROM;
  end

  // With WAIT_CYC=0 the accept edge is also the RESP-entry edge, so the
  // response is built from the live inputs while IDLE and from the latches otherwise.
  always_comb begin
    idle      = (state_q == IDLE);
    kind_eff  = idle ? kind_in : kind_q;
    addr_eff  = idle ? addr    : addr_q;
    wdata_eff = idle ? wdata   : wdata_q;
    ram_idx   = addr_eff[RAM_AW-1:0];
    oor       = (addr_eff >> RAM_AW) != 8'h00;

    state_d = state_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    to_resp = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          kind_d  = kind_in;
          addr_d  = addr;
          wdata_d = wdata;
          if (WAIT_CYC == 0) begin
            to_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYC);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) to_resp = 1'b1;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (to_resp) begin
      state_d = RESP;
      cnt_d   = '0;
    end

    bad  = (kind_eff == K_BAD) | (((kind_eff == K_RD) | (kind_eff == K_WR)) & oor);
    we   = to_resp & (kind_eff == K_WR) & !bad;
    perr = to_resp & (kind_eff == K_RD) & !bad & perr_raw;

    ready_d = to_resp;
    err_d   = to_resp & (bad | perr);
    busy_d  = (state_d != IDLE);

    rdata_d = rdata_q;
    if (to_resp) begin
      if (bad) begin
        rdata_d = '0;
      end else begin
        case (kind_eff)
          K_RD:    rdata_d = mem[ram_idx];
          K_WR:    rdata_d = wdata_eff;
          default: rdata_d = rdata_q;
        endcase
      end
    end else if ((state_q == RESP) && (kind_q == K_ROM)) begin
      rdata_d = rom_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      kind_q  <= K_BAD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[ram_idx] <= wdata_eff;
  end

`ifdef MEM_RESPONDER_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) par_mem[ram_idx] <= ^wdata_eff;
  end

  assign perr_raw = par_mem[ram_idx] != (^mem[ram_idx]);
`else
  assign perr_raw = 1'b0;
`endif

  // ROM data is passed straight through during RESP and held afterwards.
  assign rdata    = ((state_q == RESP) && (kind_q == K_ROM)) ? rom_q : rdata_q;
  assign rom_addr = addr_q;
  assign ready    = ready_q;
  assign err      = err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_CYC 0, 2, 3) driven in parallel,
// checked every cycle against a transaction-level model, plus literal spot checks.
module tb_mem_responder;

  localparam logic [4:0] S_RD  = 5'b11000;  // {ram_ena, ram_read, ram_write, rom_ena, rom_read}
  localparam logic [4:0] S_WR  = 5'b10100;
  localparam logic [4:0] S_ROM = 5'b00011;
  localparam logic [4:0] S_BAD = 5'b10111;

  logic       clk;
  logic       rst_n      [3];
  logic [4:0] strb       [3];
  logic [7:0] addr_i     [3];
  logic [7:0] wdata_i    [3];
  logic [7:0] rom_addr_o [3];
  logic [7:0] rom_q_i    [3];
  logic [7:0] rdata_o    [3];
  logic       ready_o    [3];
  logic       busy_o     [3];
  logic       err_o      [3];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // model state
  logic [7:0] m_mem [3][32];
  bit         act   [3];
  int         acc_n [3];
  bit         e_err [3];
  logic [7:0] e_rd  [3];
  logic [7:0] e_ra  [3];
  logic [7:0] held  [3];

  // values captured by the driver at the ready sample
  logic [7:0] cap_rd    [3];
  logic [7:0] cap_ra    [3];
  logic [7:0] cap_err   [3];
  logic [7:0] cap_nrdy  [3];
  logic [7:0] cap_nbusy [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : (g == 1) ? 2 : 3;
    mem_responder #(.WAIT_CYC(W), .RAM_AW(5)) u_dut (
      .clk      (clk),
      .rst      (rst_n[g]),
      .ram_ena  (strb[g][4]),
      .ram_read (strb[g][3]),
      .ram_write(strb[g][2]),
      .rom_ena  (strb[g][1]),
      .rom_read (strb[g][0]),
      .addr     (addr_i[g]),
      .wdata    (wdata_i[g]),
      .rom_addr (rom_addr_o[g]),
      .rom_q    (rom_q_i[g]),
      .rdata    (rdata_o[g]),
      .ready    (ready_o[g]),
      .busy     (busy_o[g]),
      .err      (err_o[g])
    );
    assign rom_q_i[g] = rom_addr_o[g] ^ 8'h7C;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wv(input int i);
    return (i == 0) ? 0 : (i == 1) ? 2 : 3;
  endfunction

  function automatic void chk(input string nm, input int i, input logic [7:0] a, input logic [7:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s[%0d] cyc %0d: got %h want %h", nm, i, cyc, a, e);
    end
  endfunction

  // Expected response of one accepted request, straight from the request rules.
  function automatic void model_accept(input int i, input logic [4:0] s, input logic [7:0] a,
                                       input logic [7:0] d);
    int  n_comb;
    bit  c1, c2, c3, legal;
    c1     = s[4] & s[3] & !s[2];
    c2     = s[4] & s[2] & !s[3];
    c3     = s[1] & s[0] & !s[4];
    n_comb = int'(c1) + int'(c2) + int'(c3);
    legal  = (n_comb == 1) && !(s[4] && s[1]);
    act[i]   = 1'b1;
    acc_n[i] = cyc + 1;
    e_ra[i]  = a;
    if (!legal) begin
      e_err[i] = 1'b1; e_rd[i] = 8'h00;
    end else if (c3) begin
      e_err[i] = 1'b0; e_rd[i] = a ^ 8'h7C;
    end else if (a >= 8'd32) begin
      e_err[i] = 1'b1; e_rd[i] = 8'h00;
    end else if (c2) begin
      m_mem[i][a[4:0]] = d;
      e_err[i] = 1'b0; e_rd[i] = d;
    end else begin
      e_err[i] = 1'b0; e_rd[i] = m_mem[i][a[4:0]];
    end
  endfunction

  // Called at a negedge with the instance idle; returns at the negedge of the next idle cycle.
  task automatic do_req(input int i, input logic [4:0] s, input logic [7:0] a, input logic [7:0] d);
    strb[i] = s; addr_i[i] = a; wdata_i[i] = d;
    @(posedge clk);
    model_accept(i, s, a, d);
    cap_nrdy[i] = 0; cap_nbusy[i] = 0;
    for (int k = 0; k <= wv(i); k++) begin
      @(negedge clk);
      if (busy_o[i]) cap_nbusy[i]++;
      if (ready_o[i]) begin
        cap_nrdy[i]++;
        cap_err[i] = 8'(err_o[i]);
        cap_rd[i]  = rdata_o[i];
        cap_ra[i]  = rom_addr_o[i];
      end
      strb[i] = 5'($urandom); addr_i[i] = 8'($urandom); wdata_i[i] = 8'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    strb[i] = '0;
  endtask

  // Accept a request, then pulse reset while it is still waiting.
  task automatic do_abort(input int i, input logic [4:0] s, input logic [7:0] a, input logic [7:0] d);
    strb[i] = s; addr_i[i] = a; wdata_i[i] = d;
    @(posedge clk);
    act[i] = 1'b1; acc_n[i] = cyc + 1; e_ra[i] = a; e_err[i] = 1'b0; e_rd[i] = 8'h00;
    @(negedge clk);
    strb[i] = '0;
    #2;
    rst_n[i] = 1'b0;
    act[i] = 1'b0; held[i] = 8'h00; e_ra[i] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n[i] = 1'b1;
    @(negedge clk);
  endtask

  task automatic run(input int i);
    logic [4:0] s;
    int         r;
    for (int a = 0; a < 32; a++) do_req(i, S_WR, 8'(a), 8'($urandom));

    do_req(i, S_WR, 8'h03, 8'hA5);
    do_req(i, S_RD, 8'h03, 8'h00);
    chk("rd_after_wr_data", i, cap_rd[i], 8'hA5);
    chk("rd_after_wr_err", i, cap_err[i], 8'h00);
    chk("ready_pulses", i, cap_nrdy[i], 8'd1);
    chk("busy_cycles", i, cap_nbusy[i], 8'(wv(i) + 1));

    do_req(i, S_BAD, 8'h03, 8'h3C);
    chk("illegal_err", i, cap_err[i], 8'h01);
    chk("illegal_rdata", i, cap_rd[i], 8'h00);
    do_req(i, S_RD, 8'h03, 8'h00);
    chk("illegal_no_write", i, cap_rd[i], 8'hA5);

    do_req(i, S_WR, 8'h00, 8'h11);
    do_req(i, S_WR, 8'h20, 8'h77);
    chk("oor_wr_err", i, cap_err[i], 8'h01);
    do_req(i, S_RD, 8'h00, 8'h00);
    chk("oor_no_alias", i, cap_rd[i], 8'h11);

    do_req(i, S_ROM, 8'h10, 8'h00);
    chk("rom_addr", i, cap_ra[i], 8'h10);
    chk("rom_rdata", i, cap_rd[i], 8'h6C);
    chk("rom_err", i, cap_err[i], 8'h00);

    do_req(i, S_RD, 8'h03, 8'h00);
    do_req(i, S_RD, 8'h03, 8'h00);
    chk("repeat_read", i, cap_rd[i], 8'hA5);

    if (wv(i) > 0) begin
      do_abort(i, S_WR, 8'h03, 8'h5A);
      chk("abort_rdata_reset", i, rdata_o[i], 8'h00);
      do_req(i, S_RD, 8'h03, 8'h00);
      chk("abort_old_data", i, cap_rd[i], 8'hA5);
    end

    for (int t = 0; t < 80; t++) begin
      r = int'($urandom_range(0, 99));
      if (r < 30)      s = S_RD;
      else if (r < 55) s = S_WR;
      else if (r < 80) s = S_ROM;
      else             s = 5'($urandom_range(1, 31));
      do_req(i, s, (s == S_ROM) ? 8'($urandom) : 8'($urandom_range(0, 40)), 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  initial begin : compare
    logic       xr, xb, xe;
    logic [7:0] xd, xa;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (!rst_n[i]) begin
          xr = 1'b0; xb = 1'b0; xe = 1'b0; xd = 8'h00; xa = 8'h00;
        end else begin
          xb = act[i] && (cyc >= acc_n[i]);
          xr = act[i] && (cyc == acc_n[i] + wv(i));
          xe = xr && e_err[i];
          xd = xr ? e_rd[i] : held[i];
          xa = e_ra[i];
        end
        chk("ready", i, 8'(ready_o[i]), 8'(xr));
        chk("busy", i, 8'(busy_o[i]), 8'(xb));
        chk("err", i, 8'(err_o[i]), 8'(xe));
        chk("rdata", i, rdata_o[i], xd);
        chk("rom_addr", i, rom_addr_o[i], xa);
        if (xr) begin
          held[i] = e_rd[i];
          act[i]  = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: run did not complete, got timeout want finish");
    $fatal(1);
  end

  initial begin : main
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; strb[i] = '0; addr_i[i] = '0; wdata_i[i] = '0;
      act[i] = 1'b0; acc_n[i] = 0; e_err[i] = 1'b0; e_rd[i] = '0; e_ra[i] = '0; held[i] = '0;
      cap_rd[i] = '0; cap_ra[i] = '0; cap_err[i] = '0; cap_nrdy[i] = '0; cap_nbusy[i] = '0;
    end
    repeat (3) @(negedge clk);
    #2;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(negedge clk);
    fork
      run(0);
      run(1);
      run(2);
    join
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYC, default 0, wait states inserted between request accept and response (0..15).
REQ-002 Parameter RAM_AW, default 5, data-RAM address width; RAM depth is 2^RAM_AW bytes.
REQ-003 clk  input  1  clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 ram_ena, ram_read, ram_write  input  1 each  data-RAM request strobes from the CPU controller.
REQ-006 rom_ena, rom_read  input  1 each  instruction-ROM request strobes from the CPU controller.
REQ-007 addr  input  8  access address, already selected by the CPU address mux.
REQ-008 wdata  input  8  RAM write data.
REQ-009 rom_addr  output  8  address presented to the external ROM.
REQ-010 rom_q  input  8  external ROM data, valid one cycle after rom_addr.
REQ-011 rdata  output  8  read data, valid while ready=1.
REQ-012 ready  output  1  one-cycle response pulse.
REQ-013 busy  output  1  high while in WAIT or RESP.
REQ-014 err  output  1  one-cycle error pulse, coincident with ready.

Function
REQ-015 FSM states: IDLE, WAIT, RESP.
REQ-016 A request is valid in IDLE when exactly one combination holds: {ram_ena & ram_read & !ram_write}, {ram_ena & ram_write & !ram_read}, or {rom_ena & rom_read & !ram_ena}.
REQ-017 Other nonzero strobe combinations are illegal requests (for example ram_ena & rom_ena, or ram_read & ram_write); an illegal request is accepted and completes with err=1, no RAM write, and rdata=8'h00.
REQ-018 Accept: IDLE samples the request type, addr and wdata, then moves to WAIT if WAIT_CYC>0, else to RESP.
REQ-019 WAIT counts WAIT_CYC cycles using a 4-bit down-counter, then moves to RESP; strobe changes during WAIT are ignored.
REQ-020 RESP lasts exactly one cycle, asserts ready, then returns to IDLE.
REQ-021 Latency from the accept edge to ready high is WAIT_CYC+1 cycles.
REQ-022 A RAM write commits on the edge entering RESP.
REQ-023 A RAM read returns the byte stored at the latched address; a write followed by a read of the same address returns the new data.
REQ-024 A RAM address with addr[7:RAM_AW] nonzero is out of range: err=1, no write, rdata=8'h00.
REQ-025 rom_addr is driven from the latched address for the whole access, and rdata is taken from rom_q in RESP; ROM addresses are never out of range.
REQ-026 Strobes still asserted in the cycle after RESP are accepted as a new request; repeated reads and writes are idempotent.
REQ-027 Outside RESP, rdata holds its last value, and ready=0 and err=0.

Reset
REQ-028 While rst=0: state=IDLE, counter=0, rdata=8'h00, ready=0, err=0, busy=0, rom_addr=8'h00.
REQ-029 RAM contents are not cleared by reset.
REQ-030 Reset asserted in WAIT, before the RESP edge, aborts the access: no write commits and no ready pulse is produced.
REQ-031 After rst deasserts, the first accept occurs on the first rising edge that sees a request.

Configuration
REQ-032 Macro MEM_RESPONDER_PARITY_EN: when defined, each RAM byte stores an even-parity bit computed at write.
REQ-033 With MEM_RESPONDER_PARITY_EN defined, a read whose stored parity mismatches raises err=1 with ready=1, and rdata still returns the stored byte.
REQ-034 With MEM_RESPONDER_PARITY_EN undefined, there is no parity storage and err is never caused by data.

Verification
REQ-035 WAIT_CYC=0: write addr 8'h03 wdata 8'hA5, then read 8'h03 -> ready 1 cycle after each accept, rdata=8'hA5, err=0.
REQ-036 WAIT_CYC=3: RAM read -> busy high for 4 cycles, ready high exactly 4 cycles after accept, ready width 1.
REQ-037 ram_ena=1 with rom_ena=1 -> err=1 with ready=1, and RAM at addr unchanged on readback.
REQ-038 RAM_AW=5: write to addr 8'h20 -> err=1; a subsequent read of 8'h00 shows no aliasing write.
REQ-039 ROM fetch with addr 8'h10 and rom_q=8'h6C -> rom_addr=8'h10 and rdata=8'h6C at ready.
REQ-040 WAIT_CYC=2: write issued, rst pulsed low in WAIT -> outputs at reset values, no ready, and readback shows the old data.
